// File: rtl/bcd_7seg_scan.sv
// ----------------------------------------------------------------------------
// bcd_7seg_scan
//
// Drives a multiplexed common-anode seven-segment display from packed BCD.
// A shadow register captures bcd_in on load. The digits are enabled one at a
// time, each for REFRESH_DIV clocks. Leading zeros can be blanked, and nibbles
// greater than 9 are flagged and shown as a dash.
//
// Parameters
//   NUM_DIGITS   number of digits scanned (>= 1); bcd_in is 4*NUM_DIGITS wide
//   REFRESH_DIV  clocks each digit stays enabled (>= 2)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   bcd_in      packed BCD; digit 0 (least significant) in [3:0]
//   load        capture bcd_in into the shadow register on this edge
//   blank_lz    1 = blank leading zeros (digit 0 is always shown)
//   seg_n       active-low segments {g,f,e,d,c,b,a}
//   an_n        active-low digit enables, one-hot-low while scanning
//   err         shadow holds at least one nibble > 9
//   frame_done  one-cycle pulse when the scan wraps from the last digit to 0
// ----------------------------------------------------------------------------
module bcd_7seg_scan #(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    err,
  output logic                    frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low glyph for one nibble; non-BCD codes show a dash.
  function automatic logic [6:0] glyph_of(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

  // State
  logic [4*NUM_DIGITS-1:0] shadow_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [6:0]              seg_n_reg;
  logic [NUM_DIGITS-1:0]   an_n_reg;
  logic                    err_reg;
  logic                    frame_done_reg;

  // Per-digit decode
  logic [6:0]            glyph [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] bad_in;      // incoming nibble > 9
  logic [NUM_DIGITS-1:0] zero_upper;  // shadow nibbles k..NUM_DIGITS-1 all zero
  logic                  zero_run;

  // Selected-digit outputs
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;
  logic                  last_slot;
  logic                  wrap;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign glyph[gi]  = glyph_of(shadow_reg[4*gi +: 4]);
      assign bad_in[gi] = (bcd_in[4*gi +: 4] > 4'd9);
    end
  endgenerate

  // Running AND of "nibble is zero" from the most significant digit down.
  // A non-BCD nibble is non-zero, so it stops blanking naturally.
  always_comb begin
    zero_upper = '0;
    zero_run   = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run & (shadow_reg[4*k +: 4] == 4'd0);
      zero_upper[k] = zero_run;
    end
  end

  // Outputs are computed from the pre-edge index and shadow so that an_n and
  // seg_n move together on the same edge (no ghosting).
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_reg == IDX_W'(k)) begin
        an_next[k] = 1'b0;
        if (blank_lz && (k != 0) && zero_upper[k]) begin
          seg_next = SEG_BLANK;
        end else begin
          seg_next = glyph[k];
        end
      end
    end
  end

  assign last_slot = (cnt_reg == CNT_LAST);
  assign wrap      = last_slot && (idx_reg == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_reg     <= '0;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      seg_n_reg      <= SEG_BLANK;
      an_n_reg       <= '1;
      err_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      if (load) begin
        shadow_reg <= bcd_in;
        err_reg    <= |bad_in;
      end

      seg_n_reg <= seg_next;
      an_n_reg  <= an_next;

      if (last_slot) begin
        cnt_reg <= '0;
        // With a single digit, IDX_LAST is 0 and idx simply stays 0.
        if (idx_reg == IDX_LAST) begin
          idx_reg <= '0;
        end else begin
          idx_reg <= idx_reg + 1'b1;
        end
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      frame_done_reg <= wrap;
    end
  end

  assign seg_n      = seg_n_reg;
  assign an_n       = an_n_reg;
  assign err        = err_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// ----------------------------------------------------------------------------
// tb_bcd_7seg_scan
//
// Self-checking bench for bcd_7seg_scan with NUM_DIGITS=2, REFRESH_DIV=4.
// The reference model tracks only the number of edges since reset, the
// shadow value and the error flag; the expected digit slot, frame pulse and
// glyph are derived from those with plain arithmetic and a lookup table.
// ----------------------------------------------------------------------------
module tb_bcd_7seg_scan;

  localparam int ND  = 2;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4*ND-1:0] bcd_in = '0;
  logic          load = 1'b0;
  logic          blank_lz = 1'b0;
  logic [6:0]    seg_n;
  logic [ND-1:0] an_n;
  logic          err;
  logic          frame_done;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int            m_t;       // edges since reset release
  logic [7:0]    m_shadow;
  logic          m_err;
  logic [6:0]    glyph_tab [16];

  bcd_7seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .load      (load),
    .blank_lz  (blank_lz),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .err       (err),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, expv, m_t);
    end
  endtask

  // Hold reset for n edges (load optionally asserted to show reset wins).
  task automatic do_reset(input int n, input logic ld, input logic [7:0] val);
    rst    = 1'b1;
    load   = ld;
    bcd_in = val;
    repeat (n) @(posedge clk);
    #1;
    m_t      = 0;
    m_shadow = 8'h00;
    m_err    = 1'b0;
    chk("rst_seg", {1'b0, seg_n}, 8'h7F);
    chk("rst_an", {6'b0, an_n}, 8'h03);
    chk("rst_err", {7'b0, err}, 8'h00);
    chk("rst_fd", {7'b0, frame_done}, 8'h00);
    rst  = 1'b0;
    load = 1'b0;
  endtask

  // One clock with the given inputs, then compare every output to the model.
  task automatic step(input logic ld, input logic [7:0] val, input logic blz);
    int         slot;
    logic [3:0] nib;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    logic       exp_fd;
    load     = ld;
    bcd_in   = val;
    blank_lz = blz;
    @(posedge clk);
    // Expectations use the model as it was before this edge.
    slot    = (m_t / DIV) % ND;
    nib     = (slot == 0) ? m_shadow[3:0] : m_shadow[7:4];
    exp_an  = (slot == 0) ? 2'b10 : 2'b01;
    exp_seg = glyph_tab[nib];
    if (blz && slot > 0 && ((m_shadow >> (4 * slot)) == 0)) exp_seg = 7'h7F;
    exp_fd  = (((m_t + 1) % (DIV * ND)) == 0);
    m_t++;
    if (ld) begin
      m_shadow = val;
      m_err    = (val[3:0] > 4'd9) || (val[7:4] > 4'd9);
    end
    #1;
    chk("seg_n", {1'b0, seg_n}, {1'b0, exp_seg});
    chk("an_n", {6'b0, an_n}, {6'b0, exp_an});
    chk("err", {7'b0, err}, {7'b0, m_err});
    chk("frame_done", {7'b0, frame_done}, {7'b0, exp_fd});
    $display("step t=%0d load=%0b bcd=%h blz=%0b -> seg_n=%h an_n=%b err=%0b fd=%0b",
             m_t, ld, val, blz, seg_n, an_n, err, frame_done);
  endtask

  initial begin
    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    m_t      = 0;
    m_shadow = 8'h00;
    m_err    = 1'b0;

    // 1: reset for 3 cycles with load asserted; reset must win.
    do_reset(3, 1'b1, 8'h59);
    repeat (8) step(1'b0, 8'h00, 1'b0);

    // 2: 59, no blanking, two full frames.
    step(1'b1, 8'h59, 1'b0);
    repeat (16) step(1'b0, 8'h00, 1'b0);

    // 3: 07 with blanking, then 00 with and without blanking.
    step(1'b1, 8'h07, 1'b1);
    repeat (16) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b1);
    repeat (8) step(1'b0, 8'h00, 1'b1);
    repeat (8) step(1'b0, 8'h00, 1'b0);

    // 4: non-BCD nibble sets err, a valid load clears it.
    step(1'b1, 8'h3C, 1'b0);
    repeat (8) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h42, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0);

    // 5: reset in the middle of the digit-1 slot.
    step(1'b1, 8'h93, 1'b0);
    while (!(((m_t / DIV) % ND) == 1 && (m_t % DIV) == 2)) step(1'b0, 8'h00, 1'b0);
    do_reset(1, 1'b0, 8'h00);
    repeat (8) step(1'b0, 8'h00, 1'b0);

    // 6: load held high, bcd_in walks 0x00..0x59 one value per cycle.
    for (int v = 0; v <= 8'h59; v++) step(1'b1, 8'(v), 1'($urandom_range(0, 1)));

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom));
      end else if ($urandom_range(0, 1) == 0) begin
        // Mostly valid BCD, sometimes zeros, sometimes arbitrary bytes.
        case ($urandom_range(0, 3))
          0:       step(1'b1, 8'h00, 1'($urandom_range(0, 1)));
          1:       step(1'b1, {4'h0, 4'($urandom_range(0, 9))}, 1'($urandom_range(0, 1)));
          2:       step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
          default: step(1'b1, {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
                        1'($urandom_range(0, 1)));
        endcase
      end else begin
        step(1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
